lockstep_checker: RTL and testbench

Synthesizable, parametrised lockstep comparator that replaces per-stage ad-hoc task checks in the CPU benches. It accepts NUM_CH observation channels (for example fetch, decode, execute and writeback bundles) from the pipelined `cpu` DUT and from `cpu_model`. Per-channel skew FIFOs absorb stall and flush timing differences between the two sides. It compares entries in order, counts mismatches, tracks halt agreement and a cycle watchdog, and reports a sticky pass/fail verdict with a fail code.

---
 rtl/lockstep_pkg.sv | 24 ++
 rtl/lockstep_if.sv | 53 +++++
 rtl/lockstep_skew_fifo.sv | 48 ++++
 rtl/lockstep_checker.sv | 202 ++++++++++++++++++++
 tb/tb_lockstep_checker.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep checker: FSM states, verdict codes and a width helper.
package lockstep_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_MISMATCH = 3'd1,
        FC_OVERFLOW = 3'd2,
        FC_HLT_SKEW = 3'd3,
        FC_TIMEOUT  = 3'd4,
        FC_DRAIN    = 3'd5
    } fail_code_t;

    // Index width that stays at least one bit for single-channel builds.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lockstep_if.sv
// Observation/verdict bundle between the CPU benches and lockstep_checker.
// Capture signals exist only when LOCKSTEP_CAPTURE_EN is defined.
interface lockstep_if
    import lockstep_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 64,
    parameter int TIMEOUT_W = 20
);
    localparam int CH_W = clog2_min1(NUM_CH);

    logic [NUM_CH-1:0]        dut_valid;
    logic [NUM_CH*DATA_W-1:0] dut_data;
    logic [NUM_CH-1:0]        model_valid;
    logic [NUM_CH*DATA_W-1:0] model_data;
    logic [NUM_CH-1:0]        ch_mask;
    logic                     dut_hlt;
    logic                     model_hlt;
    logic [TIMEOUT_W-1:0]     timeout_limit;

    logic                     done;
    logic                     pass;
    logic [2:0]               fail_code;
    logic [NUM_CH-1:0]        err_ch;
    logic [15:0]              mismatch_cnt;
    logic [31:0]              cycle_cnt;
`ifdef LOCKSTEP_CAPTURE_EN
    logic                     cap_valid;
    logic [CH_W-1:0]          cap_ch;
    logic [DATA_W-1:0]        cap_dut;
    logic [DATA_W-1:0]        cap_model;
    logic [31:0]              cap_cycle;
`endif

    modport master (
        output dut_valid, dut_data, model_valid, model_data, ch_mask,
               dut_hlt, model_hlt, timeout_limit,
        input  done, pass, fail_code, err_ch, mismatch_cnt, cycle_cnt
`ifdef LOCKSTEP_CAPTURE_EN
        , input cap_valid, cap_ch, cap_dut, cap_model, cap_cycle
`endif
    );

    modport slave (
        input  dut_valid, dut_data, model_valid, model_data, ch_mask,
               dut_hlt, model_hlt, timeout_limit,
        output done, pass, fail_code, err_ch, mismatch_cnt, cycle_cnt
`ifdef LOCKSTEP_CAPTURE_EN
        , output cap_valid, cap_ch, cap_dut, cap_model, cap_cycle
`endif
    );

endinterface

// File: rtl/lockstep_skew_fifo.sv
// Small skew FIFO with combinational head; a push into a full FIFO is legal
// only when the same cycle pops, otherwise it is dropped and flagged.
module lockstep_skew_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/lockstep_checker.sv
// In-order DUT/model lockstep comparator with halt-skew, watchdog and drain checks.
// Optional first-mismatch capture outputs are built when LOCKSTEP_CAPTURE_EN is defined.
module lockstep_checker
    import lockstep_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 64,
    parameter int SKEW_DEPTH = 4,
    parameter int HLT_SKEW   = 8,
    parameter int TIMEOUT_W  = 20
) (
    input logic     clk,
    input logic     rst_n,
    lockstep_if.slave bus
);
    localparam int DRN_W = $clog2(SKEW_DEPTH + 1);
    localparam int CH_W  = clog2_min1(NUM_CH);

    state_t            state_reg, state_next;
    fail_code_t        fc_reg, fc_next, term_fc;
    logic [31:0]       cycle_reg, cycle_next;
    logic [15:0]       mis_reg, mis_next;
    logic [16:0]       mis_sum;
    logic [NUM_CH-1:0] err_reg, err_next;
    logic              dh_reg, dh_next, mh_reg, mh_next;
    logic [15:0]       skew_reg, skew_next;
    logic [DRN_W-1:0]  drain_reg, drain_next;

    logic              active;
    logic [NUM_CH-1:0] d_push, m_push, d_empty, m_empty, d_drop, m_drop;
    logic [NUM_CH-1:0] cmp_en, mism, drop;
    logic [DATA_W-1:0] d_head [NUM_CH];
    logic [DATA_W-1:0] m_head [NUM_CH];

    assign active = (state_reg != DONE);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign d_push[gi] = bus.dut_valid[gi]   && bus.ch_mask[gi] && active;
            assign m_push[gi] = bus.model_valid[gi] && bus.ch_mask[gi] && active;
            assign cmp_en[gi] = !d_empty[gi] && !m_empty[gi] && active;
            assign mism[gi]   = cmp_en[gi] && (d_head[gi] != m_head[gi]);
            assign drop[gi]   = d_drop[gi] || m_drop[gi];

            lockstep_skew_fifo #(.WIDTH(DATA_W), .DEPTH(SKEW_DEPTH)) u_dut_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (d_push[gi]),
                .push_data (bus.dut_data[gi*DATA_W +: DATA_W]),
                .pop       (cmp_en[gi]),
                .full      (),
                .empty     (d_empty[gi]),
                .head      (d_head[gi]),
                .drop      (d_drop[gi])
            );

            lockstep_skew_fifo #(.WIDTH(DATA_W), .DEPTH(SKEW_DEPTH)) u_model_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (m_push[gi]),
                .push_data (bus.model_data[gi*DATA_W +: DATA_W]),
                .pop       (cmp_en[gi]),
                .full      (),
                .empty     (m_empty[gi]),
                .head      (m_head[gi]),
                .drop      (m_drop[gi])
            );
        end
    endgenerate

    always_comb begin
        mis_sum = {1'b0, mis_reg};
        for (int i = 0; i < NUM_CH; i++) begin
            mis_sum = mis_sum + 17'(mism[i]);
        end
        mis_next = mis_sum[16] ? 16'hFFFF : mis_sum[15:0];
        err_next = err_reg | mism | drop;
    end

    always_comb begin
        state_next = state_reg;
        cycle_next = cycle_reg;
        dh_next    = dh_reg;
        mh_next    = mh_reg;
        skew_next  = skew_reg;
        drain_next = drain_reg;
        term_fc    = FC_NONE;
        fc_next    = fc_reg;
        case (state_reg)
            RUN: begin
                cycle_next = cycle_reg + 32'd1;
                dh_next    = dh_reg | bus.dut_hlt;
                mh_next    = mh_reg | bus.model_hlt;
                if (dh_reg && mh_reg) begin
                    state_next = DRAIN;
                    drain_next = '0;
                end else if (dh_reg ^ mh_reg) begin
                    // Counts only edges after the first halt was latched.
                    if (skew_reg >= 16'(HLT_SKEW)) begin
                        state_next = DONE;
                        term_fc    = FC_HLT_SKEW;
                    end else begin
                        skew_next = skew_reg + 16'd1;
                    end
                end else if ((bus.timeout_limit != '0) &&
                             (cycle_next >= 32'(bus.timeout_limit))) begin
                    state_next = DONE;
                    term_fc    = FC_TIMEOUT;
                end
            end
            DRAIN: begin
                if (&(d_empty & m_empty)) begin
                    state_next = DONE;
                end else if (drain_reg == DRN_W'(SKEW_DEPTH)) begin
                    state_next = DONE;
                    term_fc    = FC_DRAIN;
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end
            default: begin
            end
        endcase
        if (fc_reg == FC_NONE) begin
            if (|mism)      fc_next = FC_MISMATCH;
            else if (|drop) fc_next = FC_OVERFLOW;
            else            fc_next = term_fc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            fc_reg    <= FC_NONE;
            cycle_reg <= '0;
            mis_reg   <= '0;
            err_reg   <= '0;
            dh_reg    <= 1'b0;
            mh_reg    <= 1'b0;
            skew_reg  <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            fc_reg    <= fc_next;
            cycle_reg <= cycle_next;
            mis_reg   <= mis_next;
            err_reg   <= err_next;
            dh_reg    <= dh_next;
            mh_reg    <= mh_next;
            skew_reg  <= skew_next;
            drain_reg <= drain_next;
        end
    end

    assign bus.done         = (state_reg == DONE);
    assign bus.pass         = (state_reg == DONE) && (fc_reg == FC_NONE);
    assign bus.fail_code    = fc_reg;
    assign bus.err_ch       = err_reg;
    assign bus.mismatch_cnt = mis_reg;
    assign bus.cycle_cnt    = cycle_reg;

`ifdef LOCKSTEP_CAPTURE_EN
    logic              cap_valid_reg;
    logic [CH_W-1:0]   cap_ch_reg, cap_sel;
    logic [DATA_W-1:0] cap_dut_reg, cap_model_reg;
    logic [31:0]       cap_cycle_reg;

    // Descending scan so the lowest mismatching channel wins.
    always_comb begin
        cap_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mism[i]) cap_sel = CH_W'(i);
        end
    end

    // cap_cycle holds cycle_cnt as seen during the compare cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_reg <= 1'b0;
            cap_ch_reg    <= '0;
            cap_dut_reg   <= '0;
            cap_model_reg <= '0;
            cap_cycle_reg <= '0;
        end else if (!cap_valid_reg && (|mism)) begin
            cap_valid_reg <= 1'b1;
            cap_ch_reg    <= cap_sel;
            cap_dut_reg   <= d_head[cap_sel];
            cap_model_reg <= m_head[cap_sel];
            cap_cycle_reg <= cycle_reg;
        end
    end

    assign bus.cap_valid = cap_valid_reg;
    assign bus.cap_ch    = cap_ch_reg;
    assign bus.cap_dut   = cap_dut_reg;
    assign bus.cap_model = cap_model_reg;
    assign bus.cap_cycle = cap_cycle_reg;
`else
    // No capture state in this build.
`endif

endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker: pass, mismatch, overflow, halt skew,
// timeout, drain residue and mid-run reset, with hand-computed expectations.
module tb_lockstep_checker;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 64;
    localparam int TW     = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    lockstep_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_W(TW)) bus ();

    lockstep_checker #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SKEW_DEPTH(4), .HLT_SKEW(8), .TIMEOUT_W(TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic go_to(input int k);
        while (cyc < k) step(1);
    endtask

    task automatic clear_inputs();
        bus.dut_valid     = '0;
        bus.dut_data      = '0;
        bus.model_valid   = '0;
        bus.model_data    = '0;
        bus.ch_mask       = 4'hF;
        bus.dut_hlt       = 1'b0;
        bus.model_hlt     = 1'b0;
        bus.timeout_limit = '0;
    endtask

    task automatic set_dut(input int c, input logic [63:0] v);
        bus.dut_valid[c] = 1'b1;
        bus.dut_data[c*DATA_W +: DATA_W] = v;
    endtask

    task automatic set_model(input int c, input logic [63:0] v);
        bus.model_valid[c] = 1'b1;
        bus.model_data[c*DATA_W +: DATA_W] = v;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".done"}, 64'(bus.done), 64'd0);
        check({tag, ".pass"}, 64'(bus.pass), 64'd0);
        check({tag, ".fail_code"}, 64'(bus.fail_code), 64'd0);
        check({tag, ".err_ch"}, 64'(bus.err_ch), 64'd0);
        check({tag, ".mismatch_cnt"}, 64'(bus.mismatch_cnt), 64'd0);
        check({tag, ".cycle_cnt"}, 64'(bus.cycle_cnt), 64'd0);
`ifdef LOCKSTEP_CAPTURE_EN
        check({tag, ".cap_valid"}, 64'(bus.cap_valid), 64'd0);
`endif
    endtask

    // Hold reset over two clock edges, check cleared outputs, release on a falling edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        clear_inputs();

        // Identical streams on ch0, model two cycles late; masked-out ch1 floods.
        do_reset("t1_reset");
        bus.timeout_limit = 20'd100;
        bus.ch_mask = 4'b1101;
        set_dut(0, 64'h1111); set_dut(1, 64'h9);
        step(1);
        set_dut(0, 64'h2222);
        step(1);
        bus.dut_valid[0] = 1'b0;
        set_model(0, 64'h1111);
        step(1);
        set_model(0, 64'h2222);
        step(1);
        check("t1_mis_mid", 64'(bus.mismatch_cnt), 64'd0);
        bus.model_valid = '0;
        step(1);
        bus.dut_valid = '0;
        check("t1_err_mid", 64'(bus.err_ch), 64'd0);
        go_to(19);
        bus.dut_hlt = 1'b1; bus.model_hlt = 1'b1;
        step(1);
        bus.dut_hlt = 1'b0; bus.model_hlt = 1'b0;
        step(1);
        check("t1_done_drain", 64'(bus.done), 64'd0);
        step(1);
        check("t1_done", 64'(bus.done), 64'd1);
        check("t1_pass", 64'(bus.pass), 64'd1);
        check("t1_fc", 64'(bus.fail_code), 64'd0);
        check("t1_mis", 64'(bus.mismatch_cnt), 64'd0);
        check("t1_cycle", 64'(bus.cycle_cnt), 64'd21);

        // Single mismatch on ch2.
        do_reset("t2_reset");
        bus.timeout_limit = 20'd100;
        set_dut(2, 64'hAAAA); set_model(2, 64'hAAAB);
        step(1);
        bus.dut_valid = '0; bus.model_valid = '0;
        check("t2_mis_latency", 64'(bus.mismatch_cnt), 64'd0);
        step(1);
        check("t2_mis", 64'(bus.mismatch_cnt), 64'd1);
        check("t2_err", 64'(bus.err_ch), 64'b0100);
        check("t2_fc_early", 64'(bus.fail_code), 64'd1);
        go_to(29);
        bus.dut_hlt = 1'b1; bus.model_hlt = 1'b1;
        step(3);
        check("t2_done", 64'(bus.done), 64'd1);
        check("t2_pass", 64'(bus.pass), 64'd0);
        check("t2_fc", 64'(bus.fail_code), 64'd1);
`ifdef LOCKSTEP_CAPTURE_EN
        check("t2_cap_valid", 64'(bus.cap_valid), 64'd1);
        check("t2_cap_ch", 64'(bus.cap_ch), 64'd2);
        check("t2_cap_dut", bus.cap_dut, 64'hAAAA);
        check("t2_cap_model", bus.cap_model, 64'hAAAB);
        check("t2_cap_cycle", 64'(bus.cap_cycle), 64'd1);
`endif

        // Overflow on ch1; ch0 pushes into a full FIFO while popping (legal).
        do_reset("t3_reset");
        for (int k = 1; k <= 5; k++) begin
            set_dut(0, 64'(k)); set_dut(1, 64'(k));
            if (k == 4) set_model(0, 64'd1);
            else bus.model_valid[0] = 1'b0;
            step(1);
            if (k == 4) begin
                check("t3_fc_at4", 64'(bus.fail_code), 64'd0);
                check("t3_err_at4", 64'(bus.err_ch), 64'd0);
            end
        end
        bus.dut_valid = '0; bus.model_valid = '0;
        check("t3_fc", 64'(bus.fail_code), 64'd2);
        check("t3_err", 64'(bus.err_ch), 64'b0010);
        check("t3_mis", 64'(bus.mismatch_cnt), 64'd0);

        // DUT halts at cycle 10, model never.
        do_reset("t4_reset");
        go_to(9);
        bus.dut_hlt = 1'b1;
        step(1);
        bus.dut_hlt = 1'b0;
        go_to(18);
        check("t4_done_18", 64'(bus.done), 64'd0);
        step(1);
        check("t4_done_19", 64'(bus.done), 64'd1);
        check("t4_fc", 64'(bus.fail_code), 64'd3);
        check("t4_cycle", 64'(bus.cycle_cnt), 64'd19);

        // Watchdog at 50, then disabled watchdog.
        do_reset("t5_reset");
        bus.timeout_limit = 20'd50;
        go_to(49);
        check("t5_done_49", 64'(bus.done), 64'd0);
        step(1);
        check("t5_done_50", 64'(bus.done), 64'd1);
        check("t5_fc", 64'(bus.fail_code), 64'd4);
        check("t5_cycle", 64'(bus.cycle_cnt), 64'd50);
        step(5);
        check("t5_frozen", 64'(bus.cycle_cnt), 64'd50);
        do_reset("t5b_reset");
        step(500);
        check("t5b_done", 64'(bus.done), 64'd0);
        check("t5b_cycle", 64'(bus.cycle_cnt), 64'd500);

        // Drain residue: two unmatched DUT entries on ch3.
        do_reset("t6_reset");
        set_dut(3, 64'h5); step(1);
        set_dut(3, 64'h6); step(1);
        bus.dut_valid = '0;
        bus.dut_hlt = 1'b1; bus.model_hlt = 1'b1;
        step(6);
        check("t6_done_8", 64'(bus.done), 64'd0);
        step(1);
        check("t6_done_9", 64'(bus.done), 64'd1);
        check("t6_fc", 64'(bus.fail_code), 64'd5);
        check("t6_cycle", 64'(bus.cycle_cnt), 64'd4);

        // Reset during DRAIN with residue, then a clean run.
        do_reset("t7_reset");
        set_dut(3, 64'h7); set_model(3, 64'h8); step(1);
        bus.model_valid = '0;
        set_dut(3, 64'h9); step(1);
        bus.dut_valid = '0;
        check("t7_mis", 64'(bus.mismatch_cnt), 64'd1);
        bus.dut_hlt = 1'b1; bus.model_hlt = 1'b1;
        step(4);
        check("t7_in_drain", 64'(bus.done), 64'd0);
        check("t7_cycle_pre", 64'(bus.cycle_cnt), 64'd4);
        rst_n = 1'b0;
        #1;
        check_zero("t7_async");
        do_reset("t7_rerun_reset");
        set_dut(0, 64'h42); set_model(0, 64'h42); step(1);
        bus.dut_valid = '0; bus.model_valid = '0;
        go_to(4);
        bus.dut_hlt = 1'b1; bus.model_hlt = 1'b1;
        step(3);
        check("t7_rerun_done", 64'(bus.done), 64'd1);
        check("t7_rerun_pass", 64'(bus.pass), 64'd1);
        check("t7_rerun_cycle", 64'(bus.cycle_cnt), 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
